// File: rtl/nn_pkg.sv
// Shared types, constants and saturation helper for the serial MAC neuron.
// Every neuron file imports this package.
package nn_pkg;

  typedef enum logic [1:0] {ACCUM, FINISH, OUTPUT} state_t;

  localparam int ACT_RELU  = 0;
  localparam int ACT_IDENT = 1;

  // Working width for saturation; must exceed the neuron accumulator width.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                         input int out_w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/neuron_activation.sv
// Combinational back end of the neuron: fixed-point rescale, activation, saturation.
// ReLU clamps non-positive sums to zero before any saturation is applied.
module neuron_activation
  import nn_pkg::*;
#(
  parameter int ACC_W     = 39,
  parameter int FRAC_BITS = 0,
  parameter int OUT_W     = 16,
  parameter int ACT_MODE  = ACT_RELU
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] result
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [SAT_W-1:0] wide;

  assign shifted = sum >>> FRAC_BITS;
  assign wide    = {{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted};

  always_comb begin
    result = '0;
    if (ACT_MODE == ACT_RELU && (wide[SAT_W-1] || wide == '0))
      result = '0;
    else
      result = OUT_W'(sat_signed(wide, OUT_W));
  end

endmodule

// File: rtl/mac_neuron.sv
// Time-multiplexed perceptron: one MAC accumulates N_INPUTS serial (x, w) pairs,
// then bias, rescale and activation produce one result on a valid/ready stream.
//
// state  | meaning
// ACCUM  | accepting pairs, acc += x*w, count tracks pairs taken
// FINISH | one cycle: bias, shift, activate, saturate into out_data
// OUTPUT | result presented, held until out_ready
module mac_neuron
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = 50,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 0,
  parameter int OUT_W     = 16,
  parameter int ACT_MODE  = ACT_RELU
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_w,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy
);

  // Sized so N_INPUTS full-scale products plus bias can never overflow.
  localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1;
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic        [CNT_W-1:0]   count;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   biased_sum;
  logic signed [OUT_W-1:0]   act_result;

  assign prod       = in_x * in_w;
  assign prod_ext   = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext   = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
  assign biased_sum = acc + bias_ext;

  neuron_activation #(
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS),
    .OUT_W    (OUT_W),
    .ACT_MODE (ACT_MODE)
  ) u_act (
    .sum   (biased_sum),
    .result(act_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else if (clear) begin
      // out_data deliberately survives an abort; only the handshake state is dropped.
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc  <= acc + prod_ext;
            busy <= 1'b1;
            if (count == CNT_W'(N_INPUTS - 1)) begin
              count    <= '0;
              state    <= FINISH;
              in_ready <= 1'b0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        FINISH: begin
          out_data  <= act_result;
          out_valid <= 1'b1;
          acc       <= '0;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_neuron.sv
// Bench for mac_neuron: three parameterisations driven in lockstep, results
// checked by per-instance scoreboard queues plus hand-written handshake sequences.
module tb_mac_neuron;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset, clear, in_valid, out_ready;
  logic signed [15:0] in_x, in_w, bias;

  logic ir_r, ir_i, ir_f, ov_r, ov_i, ov_f, busy_r, busy_i, busy_f;
  logic signed [15:0] od_r, od_i, od_f;

  always #5 clk = ~clk;

  mac_neuron #(.N_INPUTS(N), .DATA_W(16), .FRAC_BITS(0), .OUT_W(16), .ACT_MODE(0)) dut_relu (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir_r),
    .in_x(in_x), .in_w(in_w), .bias(bias), .out_valid(ov_r), .out_ready(out_ready),
    .out_data(od_r), .busy(busy_r));

  mac_neuron #(.N_INPUTS(N), .DATA_W(16), .FRAC_BITS(0), .OUT_W(16), .ACT_MODE(1)) dut_ident (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir_i),
    .in_x(in_x), .in_w(in_w), .bias(bias), .out_valid(ov_i), .out_ready(out_ready),
    .out_data(od_i), .busy(busy_i));

  mac_neuron #(.N_INPUTS(N), .DATA_W(16), .FRAC_BITS(8), .OUT_W(16), .ACT_MODE(0)) dut_frac (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir_f),
    .in_x(in_x), .in_w(in_w), .bias(bias), .out_valid(ov_f), .out_ready(out_ready),
    .out_data(od_f), .busy(busy_f));

  typedef struct {
    int x[N];
    int w[N];
    int b;
    int exp_r;   // FRAC_BITS=0, ReLU
    int exp_i;   // FRAC_BITS=0, identity
    int exp_f;   // FRAC_BITS=8, ReLU
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  longint q_r[$], q_i[$], q_f[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(int x0, int x1, int x2, int x3, int w0, int w1, int w2, int w3,
                              int b, int er, int ei, int ef);
    vec_t v;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.b = b; v.exp_r = er; v.exp_i = ei; v.exp_f = ef;
    return v;
  endfunction

  // Reference: exact dot product, arithmetic shift, activation, 16-bit clamp.
  function automatic longint model(vec_t v, int frac, int act);
    longint s;
    s = longint'(v.b);
    for (int i = 0; i < N; i++) s += longint'(v.x[i]) * longint'(v.w[i]);
    s = s >>> frac;
    if (act == 0 && s <= 0) return 0;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic vec_t with_model(vec_t v);
    vec_t r;
    r = v;
    r.exp_r = int'(model(v, 0, 0));
    r.exp_i = int'(model(v, 0, 1));
    r.exp_f = int'(model(v, 8, 0));
    return r;
  endfunction

  // Scoreboards: a result is consumed on the negedge of a valid&&ready cycle.
  always @(negedge clk) if (ov_r && out_ready) begin
    if (q_r.size() == 0) check("relu_extra_output", 0, 1);
    else check("relu_result", od_r, q_r.pop_front());
  end
  always @(negedge clk) if (ov_i && out_ready) begin
    if (q_i.size() == 0) check("ident_extra_output", 0, 1);
    else check("ident_result", od_i, q_i.pop_front());
  end
  always @(negedge clk) if (ov_f && out_ready) begin
    if (q_f.size() == 0) check("frac_extra_output", 0, 1);
    else check("frac_result", od_f, q_f.pop_front());
  end

  // Drives N pairs starting just after a posedge; returns 1 time unit after the last accept edge.
  task automatic send_pairs(input vec_t v, input bit push, input bit chk_lat);
    if (push) begin
      q_r.push_back(v.exp_r);
      q_i.push_back(v.exp_i);
      q_f.push_back(v.exp_f);
    end
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_x = 16'(v.x[i]);
      in_w = 16'(v.w[i]);
      bias = 16'(v.b);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (chk_lat) begin
      @(negedge clk); check("lat_finish_cycle", ov_r, 0);
      @(negedge clk); check("lat_output_cycle", ov_r, 1);
      @(negedge clk); check("lat_single_pulse", ov_r, 0);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && (q_r.size() + q_i.size() + q_f.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, q_r.size() + q_i.size() + q_f.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    bit saw_valid;

    vecs.push_back(mk(1, 2, 3, 4, 5, 6, 7, 8, 10, 80, 80, 0));
    vecs.push_back(mk(1, 1, 1, 1, -5, -5, -5, -5, 0, 0, -20, 0));
    vecs.push_back(mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 0, 32767, 32767, 32767));
    vecs.push_back(mk(32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768, 0, 0, -32768, 0));
    vecs.push_back(mk(256, 256, 256, 256, 512, 512, 512, 512, 0, 32767, 32767, 2048));
    vecs.push_back(mk(-3, 7, 100, -2, 4, -2, 3, 9, -5, 251, 251, 0));
    vecs.push_back(mk(-1000, 2000, -3000, 400, 300, -100, 50, -7, 123, 0, -32768, 0));
    vecs.push_back(mk(100, 200, -50, 10, 3, 4, 5, 6, -1200, 0, -290, 0));
    vecs.push_back(mk(1000, 1000, 1000, 1000, 1000, -200, 300, 100, 5000, 32767, 32767, 4707));
    for (int k = 0; k < 4; k++) begin
      v = mk(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 2000)) - 1000,
             int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 300)) - 150,
             int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 2000)) - 1000,
             int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, 65535)) - 32768, 0, 0, 0);
      vecs.push_back(with_model(v));
    end

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_w = '0; bias = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {ov_r, ov_i, ov_f}, 0);
    check("rst_out_data", od_r, 0);
    check("rst_in_ready", {ir_r, ir_i, ir_f}, 3'b111);
    check("rst_busy", {busy_r, busy_i, busy_f}, 0);
    @(posedge clk); #1;

    // Table-driven results with immediate acceptance.
    for (int k = 0; k < vecs.size(); k++) begin
      send_pairs(vecs[k], 1'b1, k == 0);
      wait_drain("table_drain");
    end

    // Backpressure: result and handshake held, extra pairs ignored.
    out_ready = 1'b0;
    send_pairs(vecs[0], 1'b1, 1'b0);
    for (int i = 0; i < 10 && !ov_r; i++) @(negedge clk);
    check("bp_valid_rises", ov_r, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_x = 16'sd1000; in_w = 16'sd1000;
      @(negedge clk);
      check("bp_valid_held", ov_r, 1);
      check("bp_data_held", od_r, 80);
      check("bp_in_ready_low", ir_r, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_accepted_first_ready", ov_r, 0);
    check("bp_in_ready_back", ir_r, 1);
    check("bp_data_kept", od_r, 80);
    wait_drain("bp_drain");
    send_pairs(vecs[1], 1'b1, 1'b0);
    wait_drain("post_bp_drain");

    // Abort mid-accumulation; the pair coinciding with clear is discarded.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_x = 16'sd50; in_w = 16'sd50;
      @(posedge clk); #1;
    end
    check("busy_mid_accum", busy_r, 1);
    clear = 1'b1; in_valid = 1'b1; in_x = 16'sd7; in_w = 16'sd7;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clear_busy", busy_r, 0);
    check("clear_in_ready", ir_r, 1);
    send_pairs(with_model(mk(1, 2, 3, 4, 1, 1, 1, 1, 0, 0, 0, 0)), 1'b1, 1'b0);
    wait_drain("clear_drain");

    // Asynchronous reset while in FINISH: no result may ever appear.
    send_pairs(vecs[0], 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("rst_async_out_valid", ov_r, 0);
    check("rst_async_in_ready", ir_r, 1);
    check("rst_async_busy", busy_r, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov_r || ov_i || ov_f) saw_valid = 1'b1;
    end
    check("rst_no_result", saw_valid, 0);
    @(posedge clk); #1;
    send_pairs(vecs[5], 1'b1, 1'b0);
    wait_drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
